keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Upstream stage of the hex divider top: scans a 4x4 hex keypad, debounces, and emits one 4-bit key code per press.
- Drives active-low columns `col` and reads active-low rows `fil`.
- Its `key_valid`/`key_code` output feeds the operand-capture/divider logic, which shifts digits into operands A and B.

Parameters:
- SCAN_CYCLES, 250, clock cycles each column stays driven while scanning (>=2).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a press and to accept a release (>=2).
- REPEAT_DELAY, 50000, cycles held before the first auto-repeat (only with KEYPAD_TYPEMATIC_EN).
- REPEAT_PERIOD, 10000, cycles between auto-repeats (only with KEYPAD_TYPEMATIC_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- fil  in  4  keypad rows, active-low, asynchronous to clk
- col  out 4  keypad columns, active-low, exactly one bit low at all times
- key_valid  out 1  single-cycle pulse: key_code holds a new accepted key
- key_code  out 4  hex value of the accepted key, held until the next accept
- key_held  out 1  high from accept until release is debounced

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - col=4'b1110 (column 0); key_valid=0; key_code=4'h0; key_held=0.
  - FSM=SCAN; all counters 0; synchronizer flops=4'b1111.
- Synchronizer: fil passes through a 2-flop synchronizer (fs). All decisions use fs, which lags fil by 2 cycles.
- Key map: row r = fil[r] low, column c = col[c] low.
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: E 0 F D
- FSM states:
  - SCAN:
    - Slot counter counts 0..SCAN_CYCLES-1. On the last count, col rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
    - On that same last-count cycle, fs is sampled before rotating.
    - If any fs bit is 0: latch row = lowest index with fs=0, latch col_idx, do not rotate, go DEBOUNCE with counter=0.
  - DEBOUNCE:
    - col stays held. Each cycle, if fs[row]==0 the counter increments, else go SCAN.
    - Returning to SCAN clears the slot counter and rotates col to the next column.
    - When the counter reaches DEBOUNCE_CYCLES-1 with fs[row]==0:
      - Next cycle: key_valid=1 for exactly one cycle, key_code=map[row][col_idx], key_held=1.
      - Go HELD.
  - HELD:
    - col stays held.
    - While fs==4'b1111 the release counter increments; any 0 bit clears it.
    - At DEBOUNCE_CYCLES-1: key_held=0, col rotates to the next column, go SCAN.
- Press-to-pulse latency: DEBOUNCE_CYCLES+1 cycles after the sampling cycle that detected the row.
- Multiple rows low in one column: lowest row index wins. No ghost rejection.
- A second key pressed during HELD is ignored. Release requires all rows high.
- Reset mid-operation: outputs return to reset values asynchronously. An in-flight key produces no pulse.
- Counter widths: `$clog2` of the largest relevant parameter.

Optional Feature:
- Macro: KEYPAD_TYPEMATIC_EN.
- Defined:
  - In HELD, while fs[row]==0, a repeat counter runs.
  - First auto-repeat pulse (key_valid=1, same key_code) REPEAT_DELAY cycles after the accept pulse, then every REPEAT_PERIOD cycles.
  - Any fs[row]==1 resets the repeat counter to the delay phase.
- Undefined: exactly one key_valid pulse per press; repeat counter and REPEAT_* logic absent.

Decomposition:
- Package keypad_pkg holds:
  - state enum scan_state_t {SCAN, DEBOUNCE, HELD}
  - localparam KEY_MAP (logic [3:0] [0:3][0:3]) with the table above
  - COL_INIT = 4'b1110
- One sub-module: sync_2ff (parameterised width, reset value input) for fil.
- FSM, counters and map lookup live in keypad_scanner.

Test Plan:
Bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_PERIOD=32.
1. Reset: assert rst mid-scan -> col=1110, key_valid=0, key_code=0, key_held=0 in the same cycle (asynchronous).
2. Hold fil=4'b1101 while col=1110, for 200 cycles, then release -> exactly one key_valid pulse with key_code=4'h4, DEBOUNCE_CYCLES+1 cycles after detection; key_held falls 16 stable-high cycles (plus 2 synchronizer cycles) after release.
3. Glitch: fil=4'b1110 for 8 cycles on col=1101 -> no key_valid, FSM back to SCAN, col rotates to 1011.
4. Sequence 4, 2, 0, 8 (row/column stimulus driven by a column-aware bench model, 400 cycles per press and per release) -> key_valid pulses with codes 4, 2, 0, 8 in order, exactly four pulses.
5. Two rows low together (fil=4'b1100) on col=1011 -> key_code=4'h3 (row 0 wins); second key pressed while held -> no extra pulse.
6. KEYPAD_TYPEMATIC_EN defined, key F held 200 cycles -> pulses at accept, accept+64, accept+96, accept+128, ...; macro undefined -> single pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Holds the FSM state enum, the row/column-to-hex key map and the column reset pattern.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  localparam logic [3:0] COL_INIT = 4'b1110;

  // Indexed as KEY_MAP[row][col]; index 0 is the leftmost nibble of each row.
  localparam logic [0:3][0:3][3:0] KEY_MAP = {
    16'h123A,
    16'h456B,
    16'h789C,
    16'hE0FD
  };

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (!v[0]) return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else return 2'd3;
  endfunction

  function automatic logic [3:0] rot_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// The reset value is supplied as a port so idle-high buses come out of reset inactive.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, press/release debounce, one key_valid pulse per press.
// Define KEYPAD_TYPEMATIC_EN to add auto-repeat pulses while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 250,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
`ifdef KEYPAD_TYPEMATIC_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 50000,
  parameter int unsigned REPEAT_PERIOD   = 10000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned SLOT_W = $clog2(SCAN_CYCLES);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]        fs;
  scan_state_t       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        cidx_q, cidx_d;
  logic [3:0]        col_q, col_d;
  logic              vld_q, vld_d;
  logic [3:0]        code_q, code_d;
  logic              held_q, held_d;

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_ph_q, rep_ph_d;
`endif

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_val_i(4'b1111),
    .d_i      (fil),
    .q_o      (fs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      slot_q  <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      cidx_q  <= '0;
      col_q   <= COL_INIT;
      vld_q   <= 1'b0;
      code_q  <= 4'h0;
      held_q  <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_q    <= '0;
      rep_ph_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      cidx_q  <= cidx_d;
      col_q   <= col_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      held_q  <= held_d;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_q    <= rep_d;
      rep_ph_q <= rep_ph_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    cidx_d  = cidx_q;
    col_d   = col_q;
    vld_d   = 1'b0;
    code_d  = code_q;
    held_d  = held_q;
`ifdef KEYPAD_TYPEMATIC_EN
    rep_d    = rep_q;
    rep_ph_d = rep_ph_q;
`endif

    unique case (state_q)
      SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          // Sample rows before rotating so a hit stays on the column that produced it.
          if (fs != 4'b1111) begin
            row_d   = low_idx(fs);
            cidx_d  = low_idx(col_q);
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = rot_col(col_q);
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!fs[row_q]) begin
          if (cnt_q == DEB_LAST) begin
            vld_d   = 1'b1;
            code_d  = KEY_MAP[row_q][cidx_q];
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_d    = '0;
            rep_ph_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          slot_d  = '0;
          col_d   = rot_col(col_q);
          state_d = SCAN;
        end
      end

      HELD: begin
        // Release needs every row high, so extra keys on the held column keep it pending.
        if (fs == 4'b1111) begin
          if (cnt_q == DEB_LAST) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            slot_d  = '0;
            col_d   = rot_col(col_q);
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
`ifdef KEYPAD_TYPEMATIC_EN
        if (!fs[row_q]) begin
          if ((!rep_ph_q && rep_q == REP_DLY_LAST) || (rep_ph_q && rep_q == REP_PER_LAST)) begin
            vld_d    = 1'b1;
            rep_d    = '0;
            rep_ph_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rep_d    = '0;
          rep_ph_d = 1'b0;
        end
`endif
      end

      default: state_d = SCAN;
    endcase
  end

  assign col       = col_q;
  assign key_valid = vld_q;
  assign key_code  = code_q;
  assign key_held  = held_q;

endmodule
